// File: rtl/pcie_us_msi_pkg.sv
// Shared definitions for the UltraScale+ MSI request arbiter: FSM states, port widths,
// and the mapping from the mmenable field to the mask of allocated vectors.
package pcie_us_msi_pkg;

    localparam int unsigned MSI_INT_W  = 32;
    localparam int unsigned MSI_SEL_W  = 4;
    localparam int unsigned MSI_MMEN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } msi_state_e;

    // Allocated count is 2**mm, capped at 32 for the reserved encodings above 5.
    function automatic logic [MSI_INT_W-1:0] msi_alloc_mask(input logic [MSI_MMEN_W-1:0] mm);
        logic [MSI_INT_W-1:0] m;
        int unsigned          n;
        n = (mm > 3'd5) ? 32'd32 : (32'd1 << mm);
        m = '0;
        for (int unsigned i = 0; i < MSI_INT_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/msi_rr_arbiter.sv
// Combinational round-robin priority encoder: picks the first set request searching
// upward from one above the last grant, wrapping at N.
module msi_rr_arbiter #(
    parameter int unsigned N  = 32,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] grant_o
);

    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(last_i) + k) % N;
            if (!valid_o && req_i[IW'(idx)]) begin
                valid_o = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pcie_us_msi_irq_arb.sv
// Collects per-vector IRQ pulses into a pending register and issues them one at a time
// as MSI requests on the PCIe IP, re-pending a vector on fail or timeout.
module pcie_us_msi_irq_arb
    import pcie_us_msi_pkg::*;
#(
    parameter int unsigned MSI_COUNT = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MSI_COUNT-1:0] msi_irq,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [31:0]          cfg_interrupt_msi_int,
    output logic [3:0]           cfg_interrupt_msi_select,
    output logic [31:0]          cfg_interrupt_msi_pending_status,
    output logic                 cfg_interrupt_msi_pending_status_data_enable,
    output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
    output logic [2:0]           cfg_interrupt_msi_attr,
    output logic                 cfg_interrupt_msi_tph_present,
    output logic [1:0]           cfg_interrupt_msi_tph_type,
    output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
    output logic [3:0]           cfg_interrupt_msi_function_number,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] fail_count
);

    localparam int unsigned IW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    msi_state_e           state_q, state_d;
    logic [MSI_COUNT-1:0] pend_q, pend_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [MSI_INT_W-1:0] int_q, int_d;

    logic [MSI_INT_W-1:0] alloc_mask;
    logic [MSI_COUNT-1:0] elig;
    logic [MSI_COUNT-1:0] clr;
    logic [MSI_COUNT-1:0] refail;
    logic                 arb_valid;
    logic [IW-1:0]        arb_grant;

    // Ineligible vectors stay in pend_q; they are only masked from arbitration.
    assign alloc_mask = msi_alloc_mask(cfg_interrupt_msi_mmenable[MSI_MMEN_W-1:0]);
    assign elig       = pend_q & alloc_mask[MSI_COUNT-1:0]
                        & {MSI_COUNT{cfg_interrupt_msi_enable[0]}};

    msi_rr_arbiter #(
        .N  (MSI_COUNT),
        .IW (IW)
    ) u_arb (
        .req_i   (elig),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        fcnt_d  = fcnt_q;
        int_d   = '0;
        clr     = '0;
        refail  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d        = arb_grant;
                    last_d         = arb_grant;
                    clr[arb_grant] = 1'b1;
                    int_d[arb_grant] = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // Fail outranks a simultaneous sent; a timeout is handled as a fail.
                if (cfg_interrupt_msi_fail || (tmo_q == TW'(TIMEOUT - 1))) begin
                    refail[grant_q] = 1'b1;
                    if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (cfg_interrupt_msi_sent) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q & ~clr) | msi_irq | refail;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            last_q  <= '0;
            tmo_q   <= '0;
            fcnt_q  <= '0;
            int_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            fcnt_q  <= fcnt_d;
            int_q   <= int_d;
        end
    end

    assign cfg_interrupt_msi_int                         = int_q;
    assign cfg_interrupt_msi_select                      = '0;
    assign cfg_interrupt_msi_pending_status              = '0;
    assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num = '0;
    assign cfg_interrupt_msi_attr                        = '0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = '0;
    assign cfg_interrupt_msi_tph_st_tag                  = '0;
    assign cfg_interrupt_msi_function_number             = '0;
    assign busy                                          = (state_q != ST_IDLE);
    assign fail_count                                    = fcnt_q;

endmodule

// File: tb/tb_pcie_us_msi_irq_arb.sv
// Directed bench for the MSI request arbiter with hand-computed expected values.
module tb_pcie_us_msi_irq_arb;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] msi_irq;
    logic [3:0]  en;
    logic [11:0] mm;
    logic        sent, fail;
    logic [31:0] msi_int;
    logic [3:0]  sel;
    logic [31:0] pstat;
    logic        pstat_de;
    logic [3:0]  pstat_fn;
    logic [2:0]  attr;
    logic        tph_p;
    logic [1:0]  tph_t;
    logic [8:0]  tph_tag;
    logic [3:0]  fn;
    logic        busy;
    logic [15:0] fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcie_us_msi_irq_arb #(
        .MSI_COUNT (32),
        .TIMEOUT   (TMO),
        .CNT_WIDTH (16)
    ) dut (
        .clk                                           (clk),
        .rst_n                                         (rst_n),
        .msi_irq                                       (msi_irq),
        .cfg_interrupt_msi_enable                      (en),
        .cfg_interrupt_msi_mmenable                    (mm),
        .cfg_interrupt_msi_sent                        (sent),
        .cfg_interrupt_msi_fail                        (fail),
        .cfg_interrupt_msi_int                         (msi_int),
        .cfg_interrupt_msi_select                      (sel),
        .cfg_interrupt_msi_pending_status              (pstat),
        .cfg_interrupt_msi_pending_status_data_enable  (pstat_de),
        .cfg_interrupt_msi_pending_status_function_num (pstat_fn),
        .cfg_interrupt_msi_attr                        (attr),
        .cfg_interrupt_msi_tph_present                 (tph_p),
        .cfg_interrupt_msi_tph_type                    (tph_t),
        .cfg_interrupt_msi_tph_st_tag                  (tph_tag),
        .cfg_interrupt_msi_function_number             (fn),
        .busy                                          (busy),
        .fail_count                                    (fcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [31:0] m);
        @(negedge clk);
        msi_irq = m;
        @(negedge clk);
        msi_irq = '0;
    endtask

    // Returns the first nonzero int seen within budget cycles (0 if none).
    task automatic wait_int(input int budget, output logic [31:0] v, output int n);
        v = '0;
        n = 0;
        while (n < budget && v == '0) begin
            @(negedge clk);
            n++;
            v = msi_int;
        end
    endtask

    task automatic respond(input logic s, input logic f);
        @(negedge clk);
        sent = s;
        fail = f;
        @(negedge clk);
        sent = 1'b0;
        fail = 1'b0;
    endtask

    task automatic expect_msi(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        int          n;
        wait_int(4 * TMO, v, n);
        check(tag, v, exp);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic [31:0] v;
        int          n;
        wait_int(cycles, v, n);
        check(tag, v, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        rst_n   = 1'b0;
        msi_irq = '0;
        en      = 4'h1;
        mm      = 12'd5;
        sent    = 1'b0;
        fail    = 1'b0;
        do_reset();

        check("rst_int", msi_int, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_fcnt", {16'b0, fcnt}, 32'h0);
        check("const_outs", {sel, pstat_de, pstat_fn, attr, tph_p, tph_t, tph_tag, fn}, 32'h0);
        check("const_pstat", pstat, 32'h0);

        // 1: latency and single-cycle int
        @(negedge clk);
        msi_irq = 32'h8;
        @(negedge clk);
        msi_irq = '0;
        check("t1_int_n1", msi_int, 32'h0);
        @(negedge clk);
        check("t1_int_n2", msi_int, 32'h8);
        @(negedge clk);
        check("t1_int_n3", msi_int, 32'h0);
        check("t1_busy_wait", {31'b0, busy}, 32'h1);
        respond(1'b1, 1'b0);
        check("t1_busy_done", {31'b0, busy}, 32'h0);

        // 2: round-robin from last grant (0 after reset) -> 1, 31, 0
        do_reset();
        pulse(32'h8000_0003);
        expect_msi("t2_first", 32'h2);
        respond(1'b1, 1'b0);
        expect_msi("t2_second", 32'h8000_0000);
        respond(1'b1, 1'b0);
        expect_msi("t2_third", 32'h1);
        respond(1'b1, 1'b0);
        pulse(32'h3);
        expect_msi("t2_rr_first", 32'h2);
        respond(1'b1, 1'b0);
        expect_msi("t2_rr_second", 32'h1);
        respond(1'b1, 1'b0);

        // 3: vector outside allocation stays pending until allocation grows
        mm = 12'd2;
        pulse(32'h20);
        expect_quiet("t3_masked", 12);
        check("t3_idle", {31'b0, busy}, 32'h0);
        mm = 12'd3;
        expect_msi("t3_unmasked", 32'h20);
        respond(1'b1, 1'b0);

        // 4: fail (with sent in the same cycle) then timeout
        mm = 12'd5;
        pulse(32'h80);
        expect_msi("t4_issue", 32'h80);
        respond(1'b1, 1'b1);
        expect_msi("t4_reissue_fail", 32'h80);
        check("t4_fcnt1", {16'b0, fcnt}, 32'd1);
        wait_int(4 * TMO, v, n);
        check("t4_reissue_tmo", v, 32'h80);
        check("t4_tmo_cycles", n, TMO + 2);
        check("t4_fcnt2", {16'b0, fcnt}, 32'd2);
        respond(1'b1, 1'b0);
        expect_quiet("t4_settled", 8);

        // 5: enable gating, then coalescing of repeated pulses during flight
        en = 4'h0;
        pulse(32'h4);
        expect_quiet("t5_disabled", 8);
        en = 4'h1;
        expect_msi("t5_enabled", 32'h4);
        pulse(32'h4);
        pulse(32'h4);
        pulse(32'h4);
        check("t5_still_wait", {31'b0, busy}, 32'h1);
        respond(1'b1, 1'b0);
        expect_msi("t5_extra", 32'h4);
        respond(1'b1, 1'b0);
        expect_quiet("t5_only_one", 12);

        // 6: reset during WAIT discards the in-flight attempt and late sent
        pulse(32'h10);
        expect_msi("t6_issue", 32'h10);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        respond(1'b1, 1'b0);
        check("t6_int", msi_int, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'h0);
        check("t6_fcnt", {16'b0, fcnt}, 32'h0);
        expect_quiet("t6_no_reissue", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
